note_recorder: RTL and testbench

Records the note stream from the keyboard path as note/duration pairs quantised to quarter beats, then replays it as an additional autoplay source. It sits beside the song players: it consumes the debounced `note` code produced by the switch path, and its `note_out` feeds the top-level note mux and frequency select exactly like an autoplay song. Durations are counted in `QUARTER_BEAT` periods from `clockManager`.

---
 rtl/note_recorder.sv | 163 ++++++++++++++++
 tb/tb_note_recorder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// note_recorder: captures the live note stream as {note, duration} entries counted in
// quarter beats and replays them as an autoplay source. Define RECORDER_LOOP_EN to loop playback.
module note_recorder #(
  parameter int         DEPTH_LOG2 = 5,
  parameter int         DUR_W      = 6,
  parameter logic [3:0] REST_CODE  = 4'd0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                QUARTER_BEAT,
  input  logic                REC,
  input  logic                PLAY,
  input  logic [3:0]          note_in,
  output logic [3:0]          note_out,
  output logic                recording,
  output logic                playing,
  output logic                full,
  output logic [DEPTH_LOG2:0] length
);
  localparam int               PW      = DEPTH_LOG2 + 1;
  localparam int               EW      = DUR_W + 4;
  localparam logic [PW-1:0]    DEPTH_L = PW'(1 << DEPTH_LOG2);
  localparam logic [PW-1:0]    ONE_L   = PW'(1);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

  state_t                r_state;
  logic                  r_qb_prev;
  logic                  r_recording;
  logic                  r_playing;
  logic                  r_full;
  logic [PW-1:0]         r_length;
  logic [PW-1:0]         r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [3:0]            r_cur_note;
  logic [DUR_W-1:0]      r_dur;
  logic [DUR_W-1:0]      r_remaining;
  // Entry layout {note, dur}; deliberately not reset, length=0 hides stale data.
  logic [EW-1:0]         r_mem [1 << DEPTH_LOG2];

  logic                  w_tick;
  logic                  w_stop;
  logic                  w_rec_tick;
  logic                  w_extend;
  logic                  w_wr_en;
  logic [PW-1:0]         w_wr_next;
  logic [DEPTH_LOG2-1:0] w_rd_next;
  logic                  w_last;
  logic [DUR_W-1:0]      w_first_dur;
  logic [DUR_W-1:0]      w_next_dur;
  logic [3:0]            w_play_note;

  assign w_tick      = QUARTER_BEAT & ~r_qb_prev;
  assign w_stop      = (r_state == S_REC) && (REC || PLAY);
  // A button pulse wins over a coincident beat tick.
  assign w_rec_tick  = (r_state == S_REC) && !(REC || PLAY) && w_tick;
  assign w_extend    = (note_in == r_cur_note) && (r_dur < DUR_MAX);
  assign w_wr_en     = (w_stop && (r_dur != '0) && (r_wr_ptr < DEPTH_L)) ||
                       (w_rec_tick && !w_extend && (r_dur != '0));
  assign w_wr_next   = r_wr_ptr + ONE_L;
  assign w_rd_next   = r_rd_ptr + DEPTH_LOG2'(1);
  assign w_last      = (PW'(r_rd_ptr) + ONE_L) == r_length;
  assign w_first_dur = r_mem[0][DUR_W-1:0];
  assign w_next_dur  = r_mem[w_rd_next][DUR_W-1:0];
  assign w_play_note = r_mem[r_rd_ptr][EW-1:DUR_W];

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {r_cur_note, r_dur};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_qb_prev   <= 1'b0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
      r_full      <= 1'b0;
      r_length    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cur_note  <= REST_CODE;
      r_dur       <= '0;
      r_remaining <= '0;
    end else begin
      r_qb_prev <= QUARTER_BEAT;
      case (r_state)
        S_IDLE: begin
          if (REC) begin
            r_wr_ptr    <= '0;
            r_cur_note  <= note_in;
            r_dur       <= '0;
            r_full      <= 1'b0;
            r_recording <= 1'b1;
            r_state     <= S_REC;
          end else if (PLAY && (r_length != '0)) begin
            r_rd_ptr    <= '0;
            r_remaining <= w_first_dur;
            r_playing   <= 1'b1;
            r_state     <= S_PLAY;
          end
        end
        S_REC: begin
          if (w_stop) begin
            r_length    <= w_wr_en ? w_wr_next : r_wr_ptr;
            r_recording <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_rec_tick) begin
            if (w_extend) begin
              r_dur <= r_dur + DUR_ONE;
            end else begin
              if (r_dur != '0) begin
                r_wr_ptr <= w_wr_next;
                // Last slot just written: the note that forced the write is dropped.
                if (w_wr_next == DEPTH_L) begin
                  r_full      <= 1'b1;
                  r_length    <= DEPTH_L;
                  r_recording <= 1'b0;
                  r_state     <= S_IDLE;
                end
              end
              r_cur_note <= note_in;
              r_dur      <= DUR_ONE;
            end
          end
        end
        S_PLAY: begin
          if (PLAY) begin
            r_playing <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_tick) begin
            if (r_remaining > DUR_ONE) begin
              r_remaining <= r_remaining - DUR_ONE;
            end else if (w_last) begin
`ifdef RECORDER_LOOP_EN
              r_rd_ptr    <= '0;
              r_remaining <= w_first_dur;
`else
              r_playing   <= 1'b0;
              r_state     <= S_IDLE;
`endif
            end else begin
              r_rd_ptr    <= w_rd_next;
              r_remaining <= w_next_dur;
            end
          end
        end
        default: begin
          r_recording <= 1'b0;
          r_playing   <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign note_out  = r_playing ? w_play_note : REST_CODE;
  assign recording = r_recording;
  assign playing   = r_playing;
  assign full      = r_full;
  assign length    = r_length;
endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: a run-length model of recording predicts entries,
// record results and the per-tick playback note stream; a monitor checks what the DUT shows.
module tb_note_recorder;
  localparam int DEPTH = 32;
  localparam int DMAX  = 63;
  localparam int K_TICK = 0, K_REC_END = 1, K_PLAY_END = 2;

  logic       CLK = 1'b0, RESET = 1'b1, QUARTER_BEAT = 1'b0, REC = 1'b0, PLAY = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [3:0] note_out;
  logic       recording, playing, full;
  logic [5:0] length;

  note_recorder #(.DEPTH_LOG2(5), .DUR_W(6), .REST_CODE(4'd0)) dut (
    .CLK(CLK), .RESET(RESET), .QUARTER_BEAT(QUARTER_BEAT), .REC(REC), .PLAY(PLAY),
    .note_in(note_in), .note_out(note_out), .recording(recording), .playing(playing),
    .full(full), .length(length)
  );

  always #5 CLK = ~CLK;

  typedef struct { int kind; int a; int b; int c; } exp_t;
  exp_t sbq[$];
  int   vectors = 0, errors = 0;
  int   stim[$];
  int   mdl_n[$], mdl_d[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int kind, input int a, input int b, input int c);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input int kind, output exp_t e);
    if (sbq.size() == 0) begin
      vectors++; errors++;
      $display("FAIL sb_underflow: DUT event kind %0d with nothing expected (t=%0t)", kind, $time);
      e.kind = kind; e.a = -1; e.b = -1; e.c = -1;
    end else begin
      e = sbq.pop_front();
      check("sb_event_kind", kind, e.kind);
    end
  endtask

  // Monitor: samples just after each active edge; ticks are credited to the state shown before the edge.
  initial begin
    logic m_qb = 1'b0, m_rec = 1'b0, m_play = 1'b0;
    logic [3:0] m_note = 4'd0;
    int rec_ticks = 0, play_ticks = 0;
    bit tick;
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      tick = QUARTER_BEAT && !m_qb;
      if (m_rec && tick && !REC && !PLAY && !RESET) rec_ticks++;
      if (m_play && tick && !PLAY && !RESET) begin
        sb_pop(K_TICK, e);
        check("play_note", m_note, e.a);
        play_ticks++;
      end
      if (m_rec && !recording) begin
        sb_pop(K_REC_END, e);
        check("rec_length", length, e.a);
        check("rec_full", full, e.b);
        check("rec_ticks", rec_ticks, e.c);
      end
      if (m_play && !playing) begin
        sb_pop(K_PLAY_END, e);
        check("play_ticks", play_ticks, e.a);
        check("idle_note_out", note_out, 0);
      end
      if (recording && !m_rec) rec_ticks = 0;
      if (playing && !m_play) play_ticks = 0;
      m_qb = QUARTER_BEAT; m_rec = recording; m_play = playing; m_note = note_out;
    end
  end

  task automatic beat(input int n, input bit rec_p, input bit play_p);
    @(negedge CLK); note_in = 4'(n); QUARTER_BEAT = 1'b1; REC = rec_p; PLAY = play_p;
    @(negedge CLK); REC = 1'b0; PLAY = 1'b0;
    @(negedge CLK); QUARTER_BEAT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse(input bit r, input bit p);
    @(negedge CLK); REC = r; PLAY = p;
    @(negedge CLK); REC = 1'b0; PLAY = 1'b0;
    @(negedge CLK);
  endtask

  // Record stim[]: the buffer is the run-length code of the per-tick notes, runs split at DMAX.
  task automatic record_seq(input bit both, input bit collide);
    int en[$], ed[$];
    bit f = 0;
    int acc = 0;
    foreach (stim[i]) begin
      if (f) break;
      acc++;
      if (en.size() > 0 && en[en.size()-1] == stim[i] && ed[ed.size()-1] < DMAX)
        ed[ed.size()-1] = ed[ed.size()-1] + 1;
      else if (en.size() == DEPTH) f = 1;
      else begin en.push_back(stim[i]); ed.push_back(1); end
    end
    sb_push(K_REC_END, en.size(), int'(f), acc);
    mdl_n = en; mdl_d = ed;
    pulse(1'b1, both);
    if (both) begin
      check("both_pulse_recording", recording, 1);
      check("both_pulse_playing", playing, 0);
    end
    foreach (stim[i]) beat(stim[i], 1'b0, 1'b0);
    if (!f) begin
      if (collide) beat(int'($urandom_range(0, 15)), 1'b1, 1'b0);
      else pulse(1'b1, 1'b0);
    end
    repeat (2) @(negedge CLK);
  endtask

  function automatic int note_at(input int pos);
    int p = pos;
    foreach (mdl_d[i]) begin
      if (p < mdl_d[i]) return mdl_n[i];
      p -= mdl_d[i];
    end
    return -1;
  endfunction

  task automatic play_seq(input int nt);
    int total = 0, n;
    bit natural;
    foreach (mdl_d[i]) total += mdl_d[i];
    if (mdl_n.size() == 0) begin
      pulse(1'b0, 1'b1);
      check("play_empty_playing", playing, 0);
      return;
    end
`ifdef RECORDER_LOOP_EN
    n = nt; natural = 0;
`else
    if (nt >= total) begin n = total; natural = 1; end
    else begin n = nt; natural = 0; end
`endif
    for (int i = 0; i < n; i++) sb_push(K_TICK, note_at(i % total), 0, 0);
    sb_push(K_PLAY_END, n, 0, 0);
    pulse(1'b0, 1'b1);
    for (int i = 0; i < n; i++) beat(int'($urandom_range(0, 15)), 1'b0, 1'b0);
    if (!natural) pulse(1'b0, 1'b1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
  endtask

  initial begin
    #5_000_000;
    vectors++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, nv;
    repeat (3) @(negedge CLK);
    check("reset_note_out", note_out, 0);
    check("reset_recording", recording, 0);
    check("reset_playing", playing, 0);
    check("reset_full", full, 0);
    check("reset_length", length, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    play_seq(5);                                  // nothing recorded yet

    stim = {};                                    // 3 for 4 ticks, 5 for 2 ticks
    for (int i = 0; i < 4; i++) stim.push_back(3);
    for (int i = 0; i < 2; i++) stim.push_back(5);
    record_seq(1'b0, 1'b0);
    play_seq(9);
    play_seq(3);                                  // abort mid-playback

    stim = {};                                    // duration saturation
    for (int i = 0; i < 70; i++) stim.push_back(7);
    record_seq(1'b0, 1'b0);
    play_seq(75);

    stim = {};                                    // buffer fill with a new note every tick
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      nv = (prev + 1 + int'($urandom_range(0, 14))) % 16;
      stim.push_back(nv); prev = nv;
    end
    record_seq(1'b0, 1'b0);
    play_seq(20);

    stim = {};                                    // stop pulse on a tick while dur=2
    stim.push_back(2); stim.push_back(2);
    record_seq(1'b0, 1'b1);
    play_seq(5);

    stim = {};                                    // REC and PLAY together from IDLE
    stim.push_back(1); stim.push_back(1); stim.push_back(4);
    record_seq(1'b1, 1'b0);
    play_seq(4);

    for (int t = 0; t < 6; t++) begin
      stim = {};
      nv = int'($urandom_range(0, 3));
      for (int i = 0; i < int'($urandom_range(0, 45)); i++) begin
        if ($urandom_range(0, 2) == 0) nv = int'($urandom_range(0, 3));
        stim.push_back(nv);
      end
      record_seq(1'(($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 1)));
      play_seq(int'($urandom_range(1, 60)));
    end

    sb_push(K_REC_END, 0, 0, 5);                  // reset while recording
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat(int'($urandom_range(0, 15)), 1'b0, 1'b0);
    @(negedge CLK); RESET = 1'b1;
    #1;
    check("rst_rec_recording", recording, 0);
    check("rst_rec_length", length, 0);
    check("rst_rec_note_out", note_out, 0);
    check("rst_rec_playing", playing, 0);
    check("rst_rec_full", full, 0);
    @(negedge CLK); @(negedge CLK); RESET = 1'b0;
    mdl_n = {}; mdl_d = {};
    repeat (2) @(negedge CLK);
    play_seq(3);

    repeat (10) @(negedge CLK);
    check("scoreboard_drained", sbq.size(), 0);
    summary();
    $finish;
  end
endmodule
